// File: rtl/vga_overlay_pkg.sv
// Shared types for the VGA box overlay: counter/colour widths, bounce direction,
// packed RGB, and the per-axis bounce step used once per frame.
package vga_overlay_pkg;

  localparam int CNT_W   = 12;
  localparam int COLOR_W = 4;

  typedef logic [CNT_W:0] wide_t;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb12_t;

  typedef struct packed {
    logic [CNT_W-1:0] pos;
    dir_t             dir;
  } axis_t;

  // limit is the largest legal position (active extent minus box extent)
  function automatic axis_t axis_step(axis_t cur, wide_t limit, wide_t speed);
    axis_t nxt;
    wide_t pos_w;
    nxt   = cur;
    pos_w = wide_t'(cur.pos);
    if (cur.dir == DIR_POS) begin
      if (pos_w + speed >= limit) begin
        nxt.pos = limit[CNT_W-1:0];
        nxt.dir = DIR_NEG;
      end else begin
        nxt.pos = cur.pos + speed[CNT_W-1:0];
      end
    end else begin
      if (pos_w <= speed) begin
        nxt.pos = '0;
        nxt.dir = DIR_POS;
      end else begin
        nxt.pos = cur.pos - speed[CNT_W-1:0];
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/vga_box_overlay_if.sv
// Video bundle (sync + 4-bit RGB) between timing generator, overlay and DAC pins.
interface vga_box_overlay_if;
  import vga_overlay_pkg::*;

  logic               hsync;
  logic               vsync;
  logic [COLOR_W-1:0] r;
  logic [COLOR_W-1:0] g;
  logic [COLOR_W-1:0] b;

  modport master (output hsync, vsync, r, g, b);
  modport slave  (input  hsync, vsync, r, g, b);
endinterface

// File: rtl/vga_sync_counter.sv
// Stage 1 of the overlay: input delay registers, sync edge detect and
// pixel/line position counters rebuilt from the sync edges.
module vga_sync_counter
  import vga_overlay_pkg::*;
(
  input  logic             pixel_clock,
  input  logic             reset,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  rgb12_t           rgb_in,
  output logic             hsync_d,
  output logic             vsync_d,
  output rgb12_t           rgb_d,
  output logic             vs_rise,
  output logic [CNT_W-1:0] x_cnt,
  output logic [CNT_W-1:0] y_cnt
);

  logic hs_rise;

  assign hs_rise = hsync_in & ~hsync_d;
  assign vs_rise = vsync_in & ~vsync_d;

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      hsync_d <= 1'b0;
      vsync_d <= 1'b0;
      rgb_d   <= '0;
      x_cnt   <= '0;
      y_cnt   <= '0;
    end else begin
      hsync_d <= hsync_in;
      vsync_d <= vsync_in;
      rgb_d   <= rgb_in;
      if (hs_rise)
        x_cnt <= '0;
      else if (x_cnt != '1)
        x_cnt <= x_cnt + 1'b1;
      // frame start wins over the line start that usually coincides with it
      if (vs_rise)
        y_cnt <= '0;
      else if (hs_rise && y_cnt != '1)
        y_cnt <= y_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_box_overlay.sv
// Bouncing solid box drawn over incoming VGA video, 2-cycle sync/colour latency.
// Define VGA_BOX_OVERLAY_BLEND_EN for a 50% translucent box instead of an opaque one.
module vga_box_overlay
  import vga_overlay_pkg::*;
#(
  parameter int unsigned H_START   = 392,
  parameter int unsigned H_ACTIVE  = 1280,
  parameter int unsigned V_START   = 41,
  parameter int unsigned V_ACTIVE  = 1024,
  parameter int unsigned BOX_W     = 64,
  parameter int unsigned BOX_H     = 64,
  parameter int unsigned SPEED     = 4,
  parameter int unsigned INIT_X    = 0,
  parameter int unsigned INIT_Y    = 0,
  parameter logic [11:0] BOX_COLOR = 12'hF80
) (
  input  logic              pixel_clock,
  input  logic              reset,
  input  logic              enable,
  vga_box_overlay_if.slave  video_in,
  vga_box_overlay_if.master video_out,
  output logic [CNT_W-1:0]  box_x,
  output logic [CNT_W-1:0]  box_y,
  output logic [15:0]       frame_count
);

  if (BOX_W > H_ACTIVE || BOX_H > V_ACTIVE) begin : g_bad_box
    $error("vga_box_overlay: box larger than active area");
  end

  localparam wide_t  H_LO    = wide_t'(H_START);
  localparam wide_t  H_HI    = wide_t'(H_START + H_ACTIVE);
  localparam wide_t  V_LO    = wide_t'(V_START);
  localparam wide_t  V_HI    = wide_t'(V_START + V_ACTIVE);
  localparam wide_t  BOX_WW  = wide_t'(BOX_W);
  localparam wide_t  BOX_HW  = wide_t'(BOX_H);
  localparam wide_t  X_LIM   = wide_t'(H_ACTIVE - BOX_W);
  localparam wide_t  Y_LIM   = wide_t'(V_ACTIVE - BOX_H);
  localparam wide_t  SPD     = wide_t'(SPEED);
  localparam rgb12_t BOX_RGB = BOX_COLOR;

  logic             hsync_d, vsync_d, vs_rise;
  rgb12_t           rgb_in, rgb_d, box_rgb, mix_rgb;
  logic [CNT_W-1:0] x_cnt, y_cnt;
  wide_t            x_w, y_w, ax, ay;
  logic             active, inbox;
  axis_t            mx_q, mx_n, my_q, my_n;

  assign rgb_in = {video_in.r, video_in.g, video_in.b};

  vga_sync_counter u_sync (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .hsync_in    (video_in.hsync),
    .vsync_in    (video_in.vsync),
    .rgb_in      (rgb_in),
    .hsync_d     (hsync_d),
    .vsync_d     (vsync_d),
    .rgb_d       (rgb_d),
    .vs_rise     (vs_rise),
    .x_cnt       (x_cnt),
    .y_cnt       (y_cnt)
  );

`ifdef VGA_BOX_OVERLAY_BLEND_EN
  function automatic logic [COLOR_W-1:0] avg_ch(logic [COLOR_W-1:0] a, logic [COLOR_W-1:0] c);
    return COLOR_W'(({1'b0, a} + {1'b0, c}) >> 1);
  endfunction

  always_comb begin
    box_rgb.r = avg_ch(rgb_d.r, BOX_RGB.r);
    box_rgb.g = avg_ch(rgb_d.g, BOX_RGB.g);
    box_rgb.b = avg_ch(rgb_d.b, BOX_RGB.b);
  end
`else
  assign box_rgb = BOX_RGB;
`endif

  // all position compares are one bit wider than the counters so box+size cannot wrap
  always_comb begin
    x_w    = wide_t'(x_cnt);
    y_w    = wide_t'(y_cnt);
    ax     = x_w - H_LO;
    ay     = y_w - V_LO;
    active = (x_w >= H_LO) && (x_w < H_HI) && (y_w >= V_LO) && (y_w < V_HI);
    inbox  = active
          && (ax >= wide_t'(box_x)) && (ax < wide_t'(box_x) + BOX_WW)
          && (ay >= wide_t'(box_y)) && (ay < wide_t'(box_y) + BOX_HW);
    mix_rgb = '0;
    if (inbox)
      mix_rgb = box_rgb;
    else if (active)
      mix_rgb = rgb_d;
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      video_out.hsync <= 1'b0;
      video_out.vsync <= 1'b0;
      video_out.r     <= '0;
      video_out.g     <= '0;
      video_out.b     <= '0;
    end else begin
      video_out.hsync <= hsync_d;
      video_out.vsync <= vsync_d;
      {video_out.r, video_out.g, video_out.b} <= mix_rgb;
    end
  end

  // motion only at frame start, which falls in vertical blanking
  always_comb begin
    mx_n = mx_q;
    my_n = my_q;
    if (vs_rise && enable) begin
      mx_n = axis_step(mx_q, X_LIM, SPD);
      my_n = axis_step(my_q, Y_LIM, SPD);
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      mx_q        <= '{pos: CNT_W'(INIT_X), dir: DIR_POS};
      my_q        <= '{pos: CNT_W'(INIT_Y), dir: DIR_POS};
      frame_count <= '0;
    end else begin
      mx_q <= mx_n;
      my_q <= my_n;
      if (vs_rise)
        frame_count <= frame_count + 1'b1;
    end
  end

  assign box_x = mx_q.pos;
  assign box_y = my_q.pos;

endmodule

// File: tb/tb_vga_box_overlay.sv
// Directed self-checking bench for vga_box_overlay on a 24x12 miniature raster.
module tb_vga_box_overlay;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [11:0] box_x, box_y;
  logic [15:0] frame_count;

  vga_box_overlay_if vin ();
  vga_box_overlay_if vout ();

  vga_box_overlay #(
    .H_START   (4),
    .H_ACTIVE  (16),
    .V_START   (2),
    .V_ACTIVE  (8),
    .BOX_W     (4),
    .BOX_H     (2),
    .SPEED     (3),
    .INIT_X    (0),
    .INIT_Y    (0),
    .BOX_COLOR (12'hF80)
  ) dut (
    .pixel_clock (clk),
    .reset       (reset),
    .enable      (enable),
    .video_in    (vin),
    .video_out   (vout),
    .box_x       (box_x),
    .box_y       (box_y),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  localparam int LINE_LEN = 24;
  localparam int NLINES   = 12;
  localparam int OBS_N    = 8192;

  int          checks = 0;
  int          errors = 0;
  int          ecount = 0;
  int          line_start [NLINES];
  logic [11:0] obs_rgb [OBS_N];
  logic        obs_hs  [OBS_N];
  logic        obs_vs  [OBS_N];
  logic [11:0] exp_box;
  logic [11:0] exp_bx [5];
  logic [11:0] exp_by [5];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ecount++;
    if (ecount < OBS_N) begin
      obs_rgb[ecount] = {vout.r, vout.g, vout.b};
      obs_hs[ecount]  = vout.hsync;
      obs_vs[ecount]  = vout.vsync;
    end
  endtask

  task automatic send_line(input logic v, input logic [11:0] pix, input int idx);
    line_start[idx] = ecount + 1;
    for (int k = 0; k < LINE_LEN; k++) begin
      vin.hsync = (k == 0);
      vin.vsync = v;
      {vin.r, vin.g, vin.b} = pix;
      step();
    end
  endtask

  task automatic send_frame(input logic [11:0] pix);
    for (int l = 0; l < NLINES; l++)
      send_line(l == 0, pix, l);
  endtask

  // output produced from sample k of line l appears one observation later
  function automatic logic [11:0] pix_at(input int l, input int k);
    return obs_rgb[line_start[l] + k + 1];
  endfunction

  initial begin
    exp_bx = '{12'd3, 12'd6, 12'd9, 12'd12, 12'd9};
    exp_by = '{12'd3, 12'd6, 12'd3, 12'd0,  12'd3};
`ifdef VGA_BOX_OVERLAY_BLEND_EN
    exp_box = 12'h7B1;  // (0+F)>>1, (F+8)>>1, (2+0)>>1
`else
    exp_box = 12'hF80;
`endif

    reset  = 1'b1;
    enable = 1'b0;
    vin.hsync = 1'b1;
    vin.vsync = 1'b0;
    {vin.r, vin.g, vin.b} = 12'h000;
    repeat (3) step();
    check("rst_hsync", 16'(vout.hsync), 16'h0);
    check("rst_vsync", 16'(vout.vsync), 16'h0);
    check("rst_rgb",   16'({vout.r, vout.g, vout.b}), 16'h0);
    check("rst_box_x", 16'(box_x), 16'h0);
    check("rst_box_y", 16'(box_y), 16'h0);
    check("rst_frame", frame_count, 16'h0);

    reset = 1'b0;
    vin.hsync = 1'b0;
    repeat (2) step();

    // latency and blanking, box frozen at 0,0
    send_frame(12'hAAA);
    check("vs_lat_pre",   16'(obs_vs[line_start[0]]),      16'h0);
    check("vs_lat_rise",  16'(obs_vs[line_start[0] + 1]),  16'h1);
    check("vs_lat_fall",  16'(obs_vs[line_start[0] + 25]), 16'h0);
    check("hs_lat_pre",   16'(obs_hs[line_start[3]]),      16'h0);
    check("hs_lat_rise",  16'(obs_hs[line_start[3] + 1]),  16'h1);
    check("hs_lat_fall",  16'(obs_hs[line_start[3] + 2]),  16'h0);
    check("rgb_vblank",   16'(pix_at(0, 15)), 16'h000);
    check("rgb_hblank_l", 16'(pix_at(6, 3)),  16'h000);
    check("rgb_act_mid",  16'(pix_at(6, 15)), 16'hAAA);
    check("rgb_act_last", 16'(pix_at(6, 19)), 16'hAAA);
    check("rgb_hblank_r", 16'(pix_at(6, 20)), 16'h000);
    check("frame_1",      frame_count, 16'd1);

    // box drawing at top-left
    send_frame(12'h123);
    check("box_ax0_ay0", 16'(pix_at(2, 4)),  16'hF80);
    check("box_ax3_ay0", 16'(pix_at(2, 7)),  16'hF80);
    check("box_ax4_ay0", 16'(pix_at(2, 8)),  16'h123);
    check("box_ax0_ay1", 16'(pix_at(3, 4)),  16'hF80);
    check("box_ax0_ay2", 16'(pix_at(4, 4)),  16'h123);
    check("line1_blank", 16'(pix_at(1, 4)),  16'h000);
    check("last_line",   16'(pix_at(9, 8)),  16'h123);
    check("after_last",  16'(pix_at(10, 8)), 16'h000);
    check("frame_2",     frame_count, 16'd2);

    // bounce
    enable = 1'b1;
    for (int f = 0; f < 5; f++) begin
      send_frame(12'h123);
      check($sformatf("bounce_x_%0d", f), 16'(box_x), 16'(exp_bx[f]));
      check($sformatf("bounce_y_%0d", f), 16'(box_y), 16'(exp_by[f]));
      if (f == 3) begin
        check("edge_ax12",  16'(pix_at(2, 16)), 16'hF80);
        check("edge_ax15",  16'(pix_at(2, 19)), 16'hF80);
        check("edge_ax11",  16'(pix_at(2, 15)), 16'h123);
        check("edge_ay1",   16'(pix_at(3, 19)), 16'hF80);
        check("edge_ay2",   16'(pix_at(4, 19)), 16'h123);
      end
    end
    check("frame_7", frame_count, 16'd7);

    // freeze
    enable = 1'b0;
    repeat (5) send_frame(12'h123);
    check("freeze_x",  16'(box_x), 16'd9);
    check("freeze_y",  16'(box_y), 16'd3);
    check("frame_12",  frame_count, 16'd12);

    // box colour over a distinct background, box at 9,3
    send_frame(12'h0F2);
    check("mix_in_tl",  16'(pix_at(5, 13)), 16'(exp_box));
    check("mix_in_br",  16'(pix_at(6, 16)), 16'(exp_box));
    check("mix_out_l",  16'(pix_at(5, 12)), 16'h0F2);
    check("mix_out_b",  16'(pix_at(7, 13)), 16'h0F2);
    check("frame_13",   frame_count, 16'd13);

    // frame counter wrap
    force dut.frame_count = 16'hFFFF;
    step();
    release dut.frame_count;
    step();
    check("frame_preset", frame_count, 16'hFFFF);
    send_line(1'b1, 12'hAAA, 0);
    check("frame_wrap", frame_count, 16'h0000);

    // reset in the middle of an active line
    for (int l = 1; l < 4; l++)
      send_line(1'b0, 12'hAAA, l);
    vin.hsync = 1'b1;
    step();
    vin.hsync = 1'b0;
    repeat (8) step();
    check("pre_reset_act", 16'({vout.r, vout.g, vout.b}), 16'hAAA);
    reset = 1'b1;
    step();
    check("mid_rst_rgb",   16'({vout.r, vout.g, vout.b}), 16'h000);
    check("mid_rst_box_x", 16'(box_x), 16'h0);
    check("mid_rst_box_y", 16'(box_y), 16'h0);
    check("mid_rst_frame", frame_count, 16'h0);
    reset = 1'b0;
    repeat (6) step();
    check("post_rst_blank", 16'({vout.r, vout.g, vout.b}), 16'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
